// File: rtl/mixer_notas.sv
// Eight-key note mixer: debounced keys gate the note square waves, and the count
// of sounding notes sets the duty cycle of a 256-step PWM audio output.
module mixer_notas #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] notas,
    input  logic [7:0] teclas,
    output logic [7:0] teclas_ativas,
    output logic [3:0] nivel,
    output logic       audio_pwm
);

    localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);

    logic [7:0]  sync1_reg;
    logic [7:0]  teclas_s;
    logic [7:0]  act_reg;
    logic [7:0]  act_next;
    logic [19:0] cnt_reg  [8];
    logic [19:0] cnt_next [8];
    logic [7:0]  notas_q;
    logic [3:0]  soma;
    logic [7:0]  pwm_cnt;
    logic [3:0]  nivel_reg;
    logic [8:0]  duty;
    logic        audio_reg;

    // Two-flop synchronizer for the asynchronous pushbuttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= '0;
            teclas_s  <= '0;
        end else begin
            sync1_reg <= teclas;
            teclas_s  <= sync1_reg;
        end
    end

    // Each key counts consecutive cycles of disagreement; the state flips when
    // the count would hit DEBOUNCE_CYCLES, and any agreement restarts the count.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_debounce
            logic differs;
            logic expire;
            assign differs       = teclas_s[gi] ^ act_reg[gi];
            assign expire        = differs && (cnt_reg[gi] == DB_LAST);
            assign cnt_next[gi]  = (!differs || expire) ? 20'd0 : cnt_reg[gi] + 20'd1;
            assign act_next[gi]  = act_reg[gi] ^ expire;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_reg <= '0;
            for (int i = 0; i < 8; i++) begin
                cnt_reg[i] <= '0;
            end
        end else begin
            act_reg <= act_next;
            for (int i = 0; i < 8; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            notas_q <= '0;
        end else begin
            notas_q <= notas;
        end
    end

    always_comb begin
        soma = 4'd0;
        for (int i = 0; i < 8; i++) begin
            soma = soma + {3'b000, notas_q[i] & act_reg[i]};
        end
    end

    // Level is sampled only at the end of a period so the duty never changes mid-period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt   <= '0;
            nivel_reg <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (pwm_cnt == 8'd255) begin
                nivel_reg <= soma;
            end
        end
    end

    assign duty = {nivel_reg, 5'b00000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            audio_reg <= 1'b0;
        end else begin
            audio_reg <= ({1'b0, pwm_cnt} < duty);
        end
    end

    assign teclas_ativas = act_reg;
    assign nivel         = nivel_reg;
    assign audio_pwm     = audio_reg;

endmodule

// File: doc/mixer_notas.md
MIXER_NOTAS -- requirements
Module: mixer_notas

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz); the number of consecutive cycles a key change must persist; legal range 2..1048575.
REQ-002 SHALL have port clk, input, 1 bit; the single clock, 50 MHz system clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset, asynchronous and active-high.
REQ-004 SHALL have port notas, input, 8 bits; square waves from the note generator, same clk domain; bit 0 = do ... bit 7 = do_5.
REQ-005 SHALL have port teclas, input, 8 bits; raw pushbuttons, asynchronous, active-high; bit i enables notas[i].
REQ-006 SHALL have port teclas_ativas, output, 8 bits; the debounced key state.
REQ-007 SHALL have port nivel, output, 4 bits; the mix level latched for the current PWM period, 0..8.
REQ-008 SHALL have port audio_pwm, output, 1 bit; registered PWM audio output.

Function
REQ-009 SHALL pass teclas through a 2-flop synchronizer (teclas_s) before any other use.
REQ-010 SHALL keep one debounce counter per key (20 bits): it clears when teclas_s[i] == teclas_ativas[i] and increments otherwise.
REQ-011 SHALL toggle teclas_ativas[i] and clear counter i on the cycle the counter would reach DEBOUNCE_CYCLES; a change held for exactly DEBOUNCE_CYCLES cycles of teclas_s is accepted, and a shorter glitch is rejected with its counter cleared.
REQ-012 SHALL register notas once (notas_q) and compute soma = popcount(notas_q & teclas_ativas), 4 bits, range 0..8, with no overflow possible.
REQ-013 SHALL run a free-running 8-bit counter pwm_cnt, 0..255, that wraps 255 -> 0.
REQ-014 SHALL latch nivel <= soma on the cycle pwm_cnt == 255, so that nivel is constant over each 256-cycle period starting at pwm_cnt == 0.
REQ-015 SHALL define duty = nivel * 32 as 9 bits (0..256).
REQ-016 SHALL register audio_pwm <= (pwm_cnt < duty) each cycle, giving one cycle of latency from pwm_cnt/duty to the pin.
REQ-017 SHALL hold audio_pwm constantly 0 when nivel = 0 and constantly 1 when nivel = 8, with no glitch at the wrap.
REQ-018 SHALL make soma changes mid-period invisible at the output until the next latch.
REQ-019 SHALL debounce all eight keys independently, so simultaneous changes on several keys resolve in the same cycle.
REQ-020 SHALL ignore notas bits whose key is inactive, whatever their activity.

Reset
REQ-021 SHALL, while rst = 1, asynchronously force the synchronizer flops, notas_q, all debounce counters, teclas_ativas, pwm_cnt, nivel and audio_pwm to 0.
REQ-022 SHALL, on rst deassertion, resume with pwm_cnt = 0 on the first clk edge and all keys inactive; rst asserted mid-debounce discards the pending change.

Verification (DEBOUNCE_CYCLES = 4 in bench)
REQ-023 SHALL cover reset: rst pulsed mid-period -> all outputs 0 immediately without a clock edge; first latch of nivel at pwm_cnt == 255 after release.
REQ-024 SHALL cover debounce: teclas[5] = 1 held -> teclas_ativas[5] = 1 exactly 2 (sync) + 4 cycles later; a 3-cycle pulse on teclas[2] -> teclas_ativas[2] stays 0.
REQ-025 SHALL cover a single note: teclas_ativas = 0x01, notas[0] = 1 forced -> nivel = 1 next period; audio_pwm high for 32 of 256 cycles, starting 1 cycle after pwm_cnt == 0.
REQ-026 SHALL cover full scale: teclas_ativas = 0xFF, notas = 0xFF -> nivel = 8; audio_pwm high for all 256 cycles of the period.
REQ-027 SHALL cover masking: notas = 0xFF, teclas_ativas = 0x00 -> nivel = 0 and audio_pwm = 0 throughout.
REQ-028 SHALL cover a mid-period change: soma changes 3 -> 5 at pwm_cnt = 100 -> current period stays 96 high cycles; next period is 160 high cycles.
